// File: rtl/test_signal_generator.sv
// test_signal_generator
//
// Burst stimulus source for the echo-cancellation datapath. A start in IDLE
// latches mode, burst length and ramp step, then streams samples over a
// valid/ready handshake until the burst completes or is stopped. At the end
// of a burst, done pulses for one cycle.
//
// Modes: 0 LFSR random, 1 ramp, 2 impulse, 3 square wave.
//
// Optional feature macro: CONTINUOUS_EN. When it is defined, a start with
// n_samples == 0 streams samples until stop. When it is undefined, such a
// start goes straight to DONE and emits no samples.
//
// Ports:
//   clk_sampling  sample clock; all state changes on its rising edge
//   reset         synchronous, active-high reset
//   start         begin a burst (IDLE only)
//   stop          abort the running burst; the pending sample is dropped
//   mode          sample generator select, latched at start
//   n_samples     burst length, latched at start
//   ramp_step     ramp increment, latched at start
//   seed_load     load seed into the LFSR (IDLE only; zero loads SEED)
//   seed          LFSR seed value
//   signal        sample data, two's complement
//   signal_valid  signal holds a sample
//   signal_ready  downstream accepts the sample
//   busy          high while a burst is running
//   done          one-cycle end-of-burst pulse

module test_signal_generator #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned COUNT_W = 16,
    parameter logic [31:0] SEED    = 32'hACE1_2468,
    parameter logic [31:0] AMP     = 32'h0000_4000,
    parameter int unsigned SQ_HALF = 8
) (
    input  logic               clk_sampling,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [COUNT_W-1:0] n_samples,
    input  logic [WIDTH-1:0]   ramp_step,
    input  logic               seed_load,
    input  logic [31:0]        seed,
    output logic [WIDTH-1:0]   signal,
    output logic               signal_valid,
    input  logic               signal_ready,
    output logic               busy,
    output logic               done
);

    localparam int unsigned      PhW        = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;
    localparam logic [PhW-1:0]   PhLast     = PhW'(SQ_HALF - 1);
    localparam logic [WIDTH-1:0] AmpPos     = AMP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] AmpNeg     = ~AMP[WIDTH-1:0] + WIDTH'(1);
    localparam logic [WIDTH-1:0] ImpulseVal = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [31:0]      LfsrTaps   = 32'h8020_0003;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [WIDTH-1:0]   sample_q, sample_d;
    logic [PhW-1:0]     phase_q, phase_d;
    logic               neg_q, neg_d;

    logic        unlimited;
    logic        start_run;
    logic        xfer;
    logic        last_xfer;
    logic [31:0] seed_eff;
    logic [31:0] lfsr_next;

    assign xfer      = (state_q == StRun) && signal_ready;
    // A zero seed would lock the LFSR at zero forever.
    assign seed_eff  = (seed == 32'h0) ? SEED : seed;
    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 32'h0);

`ifdef CONTINUOUS_EN
    logic unlimited_q, unlimited_d;

    assign start_run = start;
    assign unlimited = unlimited_q;

    always_comb begin
        unlimited_d = unlimited_q;
        if (state_q == StIdle && start) begin
            unlimited_d = (n_samples == '0);
        end
    end

    always_ff @(posedge clk_sampling) begin
        if (reset) begin
            unlimited_q <= 1'b0;
        end else begin
            unlimited_q <= unlimited_d;
        end
    end
`else
    assign start_run = start && (n_samples != '0);
    assign unlimited = 1'b0;
`endif

    // stop wins over a simultaneous transfer, so that transfer never ends the burst.
    assign last_xfer = xfer && !stop && !unlimited && (count_q == COUNT_W'(1));

    // State register
    always_ff @(posedge clk_sampling) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = start_run ? StRun : StDone;
            StRun:   if (stop || last_xfer) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        signal       = sample_q;
        signal_valid = (state_q == StRun);
        busy         = (state_q == StRun);
        done         = (state_q == StDone);
    end

    // Datapath next state
    always_comb begin
        lfsr_d   = lfsr_q;
        count_d  = count_q;
        mode_d   = mode_q;
        step_d   = step_q;
        sample_d = sample_q;
        phase_d  = phase_q;
        neg_d    = neg_q;

        if (state_q == StIdle) begin
            // The seed loads first, so a same-cycle start already uses it.
            if (seed_load) lfsr_d = seed_eff;
            if (start_run) begin
                mode_d  = mode;
                count_d = n_samples;
                step_d  = ramp_step;
                phase_d = '0;
                neg_d   = 1'b0;
                unique case (mode)
                    2'd0:    sample_d = lfsr_d[WIDTH-1:0];
                    2'd1:    sample_d = '0;
                    2'd2:    sample_d = ImpulseVal;
                    default: sample_d = AmpPos;
                endcase
            end
        end else if (xfer && !stop) begin
            if (!unlimited) count_d = count_q - COUNT_W'(1);
            unique case (mode_q)
                2'd0: begin
                    lfsr_d   = lfsr_next;
                    sample_d = lfsr_next[WIDTH-1:0];
                end
                2'd1:    sample_d = sample_q + step_q;
                2'd2:    sample_d = '0;
                default: begin
                    if (phase_q == PhLast) begin
                        phase_d  = '0;
                        neg_d    = ~neg_q;
                        sample_d = neg_q ? AmpPos : AmpNeg;
                    end else begin
                        phase_d = phase_q + PhW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_sampling) begin
        if (reset) begin
            lfsr_q   <= SEED;
            count_q  <= '0;
            mode_q   <= 2'd0;
            step_q   <= '0;
            sample_q <= '0;
            phase_q  <= '0;
            neg_q    <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            step_q   <= step_d;
            sample_q <= sample_d;
            phase_q  <= phase_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: tb/tb_test_signal_generator.sv
module tb_test_signal_generator;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk_sampling;
    logic        reset;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] n_samples;
    logic [15:0] ramp_step;
    logic        seed_load;
    logic [31:0] seed;
    logic [15:0] signal;
    logic        signal_valid;
    logic        signal_ready;
    logic        busy;
    logic        done;

    test_signal_generator dut (
        .clk_sampling (clk_sampling),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .n_samples    (n_samples),
        .ramp_step    (ramp_step),
        .seed_load    (seed_load),
        .seed         (seed),
        .signal       (signal),
        .signal_valid (signal_valid),
        .signal_ready (signal_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk_sampling = 1'b0;
    always #5 clk_sampling = ~clk_sampling;

    int checks;
    int failures;

    // Observations gathered by collect()
    logic [15:0] obs_q[$];
    int n_done;
    int valid_cycles;
    int stable_err;
    int timed_out;
    int done_lat;

    // Reference model: LFSR state carried across bursts
    logic [31:0] m_lfsr;

    function automatic logic [31:0] galois(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // k-th sample of a burst, computed from the sample index
    function automatic logic [15:0] ref_sample(input int m, input int k,
                                               input logic [15:0] step,
                                               input logic [31:0] lfsr0);
        logic [31:0] v;
        case (m)
            0: begin
                v = lfsr0;
                for (int i = 0; i < k; i++) v = galois(v);
                return v[15:0];
            end
            1: return 16'(k * int'(step));
            2: return (k == 0) ? 16'h7FFF : 16'h0000;
            default: return (((k / 8) % 2) == 1) ? 16'hC000 : 16'h4000;
        endcase
    endfunction

    task automatic launch(input int m, input int n, input logic [15:0] step);
        @(posedge clk_sampling); #1;
        mode      = 2'(m);
        n_samples = 16'(n);
        ramp_step = step;
        start     = 1'b1;
    endtask

    // Drives signal_ready / stop and records transfers until done or timeout.
    task automatic collect(input int ready_pct, input logic [63:0] pat,
                           input int stop_after, input int max_cycles);
        logic [15:0] prev_sig;
        bit          prev_hold;
        int          last_x;
        bit          got_done;
        obs_q.delete();
        n_done = 0; valid_cycles = 0; stable_err = 0; timed_out = 0; done_lat = -1;
        prev_hold = 1'b0; prev_sig = '0; last_x = -1; got_done = 1'b0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            @(posedge clk_sampling); #1;
            start = 1'b0; seed_load = 1'b0; stop = 1'b0;
            if (done) begin
                n_done++;
                done_lat = (last_x < 0) ? 0 : cyc - last_x;
                got_done = 1'b1;
                signal_ready = 1'b0;
                break;
            end
            if (signal_valid) valid_cycles++;
            if (prev_hold && signal_valid && signal !== prev_sig) stable_err++;
            if (signal_valid && stop_after >= 0 && obs_q.size() == stop_after) begin
                stop = 1'b1;
                signal_ready = 1'b1;
                prev_hold = 1'b0;
            end else begin
                if (ready_pct < 0) signal_ready = (cyc < 64) ? pat[cyc] : 1'b1;
                else signal_ready = ($urandom_range(99) < ready_pct);
                if (signal_valid && signal_ready) begin
                    obs_q.push_back(signal);
                    last_x = cyc;
                end
                prev_hold = signal_valid && !signal_ready;
                prev_sig = signal;
            end
        end
        if (!got_done) timed_out = 1;
        signal_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; n_samples = '0;
        ramp_step = '0; seed_load = 1'b0; seed = '0; signal_ready = 1'b0;
        repeat (3) @(posedge clk_sampling);
        #1;
        checks++; if (signal !== 16'h0) begin failures++;
            $display("FAIL reset_signal: got %h want 0000", signal); end
        checks++; if (signal_valid !== 1'b0) begin failures++;
            $display("FAIL reset_valid: got %b want 0", signal_valid); end
        checks++; if (busy !== 1'b0) begin failures++;
            $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++;
            $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
        m_lfsr = SEED;
    endtask

    task automatic test_lfsr_burst();
        logic [15:0] want[3] = '{16'h2468, 16'h9234, 16'h491A};
        launch(0, 3, 16'h0);
        collect(100, '0, -1, 100);
        checks++; if (timed_out != 0) begin failures++;
            $display("FAIL lfsr_timeout: got %0d want 0", timed_out); end
        checks++; if (obs_q.size() != 3) begin failures++;
            $display("FAIL lfsr_count: got %0d want 3", obs_q.size()); end
        for (int k = 0; k < obs_q.size() && k < 3; k++) begin
            checks++; if (obs_q[k] !== want[k]) begin failures++;
                $display("FAIL lfsr_sample%0d: got %h want %h", k, obs_q[k], want[k]); end
        end
        checks++; if (done_lat != 1) begin failures++;
            $display("FAIL lfsr_done_latency: got %0d want 1", done_lat); end
        for (int i = 0; i < obs_q.size(); i++) m_lfsr = galois(m_lfsr);
    endtask

    task automatic test_ramp_backpressure();
        launch(1, 4, 16'hFFFE);
        collect(-1, 64'hFFFF_FFFF_FFFF_FFFC, -1, 100);
        checks++; if (obs_q.size() != 4) begin failures++;
            $display("FAIL ramp_count: got %0d want 4", obs_q.size()); end
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== ref_sample(1, k, 16'hFFFE, '0)) begin failures++;
                $display("FAIL ramp_sample%0d: got %h want %h", k, obs_q[k],
                         ref_sample(1, k, 16'hFFFE, '0)); end
        end
        checks++; if (valid_cycles != 6) begin failures++;
            $display("FAIL ramp_valid_cycles: got %0d want 6", valid_cycles); end
        checks++; if (stable_err != 0) begin failures++;
            $display("FAIL ramp_hold_stable: got %0d changes want 0", stable_err); end
    endtask

    task automatic test_square();
        launch(3, 20, 16'($urandom));
        collect(60, '0, -1, 1000);
        checks++; if (obs_q.size() != 20) begin failures++;
            $display("FAIL square_count: got %0d want 20", obs_q.size()); end
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== ref_sample(3, k, '0, '0)) begin failures++;
                $display("FAIL square_sample%0d: got %h want %h", k, obs_q[k],
                         ref_sample(3, k, '0, '0)); end
        end
        checks++; if (stable_err != 0) begin failures++;
            $display("FAIL square_hold_stable: got %0d changes want 0", stable_err); end
    endtask

    task automatic test_impulse_stop();
        int late_valid;
        launch(2, 5, 16'h0);
        collect(100, '0, 2, 100);
        checks++; if (obs_q.size() != 2) begin failures++;
            $display("FAIL stop_count: got %0d want 2", obs_q.size()); end
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== ref_sample(2, k, '0, '0)) begin failures++;
                $display("FAIL impulse_sample%0d: got %h want %h", k, obs_q[k],
                         ref_sample(2, k, '0, '0)); end
        end
        checks++; if (valid_cycles != 3) begin failures++;
            $display("FAIL stop_valid_cycles: got %0d want 3", valid_cycles); end
        checks++; if (n_done != 1) begin failures++;
            $display("FAIL stop_done: got %0d want 1", n_done); end
        late_valid = 0;
        signal_ready = 1'b1;
        repeat (4) begin
            @(posedge clk_sampling); #1;
            if (signal_valid || done) late_valid++;
        end
        signal_ready = 1'b0;
        checks++; if (late_valid != 0) begin failures++;
            $display("FAIL stop_quiet_after: got %0d active cycles want 0", late_valid); end
    endtask

    task automatic test_seed();
        logic [31:0] s;
        @(posedge clk_sampling); #1;
        seed_load = 1'b1; seed = 32'h0;
        @(posedge clk_sampling); #1;
        seed_load = 1'b0;
        m_lfsr = SEED;
        launch(0, 1, 16'h0);
        collect(100, '0, -1, 100);
        checks++; if (obs_q.size() != 1) begin failures++;
            $display("FAIL seed0_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0] !== 16'h2468) begin failures++;
                $display("FAIL seed0_sample: got %h want 2468", obs_q[0]); end
        end
        m_lfsr = galois(m_lfsr);
        // seed_load together with start: the burst uses the new seed
        s = $urandom | 32'h1;
        @(posedge clk_sampling); #1;
        seed_load = 1'b1; seed = s;
        mode = 2'd0; n_samples = 16'd4; start = 1'b1;
        collect(70, '0, -1, 500);
        checks++; if (obs_q.size() != 4) begin failures++;
            $display("FAIL seedstart_count: got %0d want 4", obs_q.size()); end
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== ref_sample(0, k, '0, s)) begin failures++;
                $display("FAIL seedstart_sample%0d: got %h want %h", k, obs_q[k],
                         ref_sample(0, k, '0, s)); end
        end
        m_lfsr = s;
        for (int i = 0; i < obs_q.size(); i++) m_lfsr = galois(m_lfsr);
    endtask

    task automatic test_empty_burst();
        launch(1, 0, 16'd3);
`ifdef CONTINUOUS_EN
        collect(100, '0, 7, 200);
        checks++; if (obs_q.size() != 7) begin failures++;
            $display("FAIL cont_count: got %0d want 7", obs_q.size()); end
        for (int k = 0; k < obs_q.size(); k++) begin
            checks++; if (obs_q[k] !== ref_sample(1, k, 16'd3, '0)) begin failures++;
                $display("FAIL cont_sample%0d: got %h want %h", k, obs_q[k],
                         ref_sample(1, k, 16'd3, '0)); end
        end
`else
        collect(100, '0, -1, 20);
        checks++; if (valid_cycles != 0) begin failures++;
            $display("FAIL empty_valid: got %0d want 0", valid_cycles); end
`endif
        checks++; if (n_done != 1) begin failures++;
            $display("FAIL empty_done: got %0d want 1", n_done); end
    endtask

    task automatic test_random_bursts();
        int m, n, pct;
        logic [15:0] step;
        for (int b = 0; b < 8; b++) begin
            m = $urandom_range(3);
            n = $urandom_range(24, 1);
            step = 16'($urandom);
            pct = $urandom_range(100, 30);
            launch(m, n, step);
            collect(pct, '0, -1, 2000);
            checks++; if (obs_q.size() != n) begin failures++;
                $display("FAIL rand%0d_count: got %0d want %0d", b, obs_q.size(), n); end
            for (int k = 0; k < obs_q.size(); k++) begin
                checks++; if (obs_q[k] !== ref_sample(m, k, step, m_lfsr)) begin failures++;
                    $display("FAIL rand%0d_mode%0d_sample%0d: got %h want %h", b, m, k,
                             obs_q[k], ref_sample(m, k, step, m_lfsr)); end
            end
            checks++; if (stable_err != 0) begin failures++;
                $display("FAIL rand%0d_hold_stable: got %0d want 0", b, stable_err); end
            checks++; if (done_lat != 1 || n_done != 1) begin failures++;
                $display("FAIL rand%0d_done: got lat %0d pulses %0d want 1 1", b,
                         done_lat, n_done); end
            if (m == 0) for (int i = 0; i < obs_q.size(); i++) m_lfsr = galois(m_lfsr);
        end
    endtask

    task automatic test_reset_midburst();
        int spurious;
        logic [15:0] want[3] = '{16'h2468, 16'h9234, 16'h491A};
        launch(0, 10, 16'h0);
        @(posedge clk_sampling); #1;
        start = 1'b0;
        signal_ready = 1'b1;
        repeat (3) @(posedge clk_sampling);
        #1;
        reset = 1'b1;
        @(posedge clk_sampling); #1;
        reset = 1'b0;
        signal_ready = 1'b0;
        checks++; if (signal_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: got valid %b busy %b done %b want 0 0 0",
                     signal_valid, busy, done); end
        spurious = 0;
        repeat (4) begin
            @(posedge clk_sampling); #1;
            if (done || signal_valid) spurious++;
        end
        checks++; if (spurious != 0) begin failures++;
            $display("FAIL midreset_no_done: got %0d active cycles want 0", spurious); end
        m_lfsr = SEED;
        launch(0, 3, 16'h0);
        collect(100, '0, -1, 100);
        checks++; if (obs_q.size() != 3) begin failures++;
            $display("FAIL midreset_count: got %0d want 3", obs_q.size()); end
        for (int k = 0; k < obs_q.size() && k < 3; k++) begin
            checks++; if (obs_q[k] !== want[k]) begin failures++;
                $display("FAIL midreset_sample%0d: got %h want %h", k, obs_q[k], want[k]); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_lfsr_burst();
        test_ramp_backpressure();
        test_square();
        test_impulse_stop();
        test_seed();
        test_empty_burst();
        test_random_bursts();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
